pe_row_collector: RTL and testbench
===================================

# pe_row_collector

Downstream drain stage for one row of the Nanci sorting mesh. Once the row's PEs signal that sorting has finished, the block snapshots every PE's `o_PE` word in one cycle. It then streams the words out one at a time, column 0 first, over a valid/ready handshake. It also checks that the streamed data fields are non-decreasing and raises flags for an unsorted row or an overrun capture request.

## Interface

Parameters:
- `N_COLS`, default 4: number of PEs in the row (≥1).
- `ADDR_WIDTH`, default 3: address field width of a PE word.
- `DATA_WIDTH`, default 3: data field width of a PE word.
- Derived `W = ADDR_WIDTH+DATA_WIDTH`: word width.
- Derived `CW = max(1, clog2(N_COLS))`: index width.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `i_sort_done`, input, 1: capture request, sampled each rising edge.
- `i_PE_row`, input, N_COLS*W: packed PE outputs; column c occupies bits [c*W +: W]. Each word is {addr (upper ADDR_WIDTH bits), data (lower DATA_WIDTH bits)}, the same layout as `o_PE`.
- `o_valid`, output, 1: `o_word` holds a valid word.
- `i_ready`, input, 1: the consumer accepts `o_word` this cycle.
- `o_word`, output, W: the current word.
- `o_index`, output, CW: column number of `o_word`.
- `o_last`, output, 1: `o_word` is column N_COLS-1.
- `o_busy`, output, 1: the block is in STREAM.
- `o_order_err`, output, 1: sticky; a data field decreased within a burst.
- `o_overrun`, output, 1: sticky; a capture request arrived while a burst was still pending.

## Operation

- A handshake occurs in a cycle where `o_valid & i_ready` is high.
- Buffer: N_COLS registers of W bits, loaded in parallel on capture.
- State IDLE:
  - `o_valid`=0, `o_busy`=0.
  - `i_sort_done`=1 loads the buffer from `i_PE_row`, sets idx=0, clears the previous-data register, and moves to STREAM.
- State STREAM:
  - `o_valid`=1, `o_busy`=1.
  - `o_word`=buf[idx], `o_index`=idx, `o_last`=(idx==N_COLS-1).
  - On a handshake with idx<N_COLS-1: idx increments and prev is set to the data field of the accepted word.
  - On a handshake with idx==N_COLS-1: go to IDLE.
  - Without a handshake, `o_word`, `o_index` and `o_last` stay stable.
- Order check: on each handshake with idx>0, if data(buf[idx]) < prev (unsigned compare), set `o_order_err`. Equal values are legal.
- `i_sort_done` in STREAM, no final handshake that cycle: the request is ignored, the buffer is unchanged, and `o_overrun` is set.
- `i_sort_done` in the same cycle as the final handshake: the request is accepted. The buffer reloads, idx=0, the block stays in STREAM, and `o_overrun` is not set. This supports back-to-back bursts.
- N_COLS=1: every handshake is the final one.
- `i_PE_row` is ignored except in capture cycles.
- `o_order_err` and `o_overrun` clear only on `rst`.

## Timing

- Reset (asynchronous, effective immediately):
  - state=IDLE, idx=0, buffer=0.
  - `o_valid`=0, `o_word`=0, `o_index`=0, `o_last`=0 (N_COLS=1: `o_last` is decoded from idx, so it reads 1).
  - `o_busy`=0, `o_order_err`=0, `o_overrun`=0.
- Reset during STREAM aborts the burst and clears all state; no partial words follow.
- Capture latency: `i_sort_done` is sampled at edge k; `o_valid`=1 with column 0 from edge k onward, i.e. visible in cycle k+1.
- Throughput: one word per cycle while `i_ready`=1. A full burst takes N_COLS cycles minimum.
- Flags update at the edge of the causing handshake or request.
- All outputs are registered or decoded from registered state. No combinational path runs from `i_ready` or `i_sort_done` to any output.

## Test plan

All scenarios use N_COLS=4, ADDR=3, DATA=3.

- **Basic drain:** row words 0o01, 0o12, 0o23, 0o34 (col0..3), pulse `i_sort_done`, `i_ready`=1.
  - Next 4 cycles `o_word` = 0o01, 0o12, 0o23, 0o34, `o_index` = 0..3.
  - `o_last` only on the 4th word; `o_busy` drops after it; both flags remain 0.
- **Backpressure:** same row, `i_ready` low in alternating cycles.
  - Each word is held stable until accepted; exactly 4 handshakes; order unchanged.
- **Order error:** row data fields 1, 4, 2, 5.
  - `o_order_err` rises at the edge accepting the word with data 2 and stays high.
  - A following sorted burst does not clear it.
- **Overrun and back-to-back:**
  - Pulse `i_sort_done` while idx=1: `o_overrun`=1, remaining words come from the original row.
  - Pulse `i_sort_done` with the final handshake: a new burst starts with column 0 of the new row on the next cycle, and `o_overrun` is unchanged by this pulse.
- **Reset mid-burst:** assert `rst` after 2 handshakes.
  - All outputs go to reset values immediately; after release, `o_valid` stays 0 until the next `i_sort_done`.
- **N_COLS=1 build:** the single word streams with `o_last`=1 and `o_index`=0, and the block returns to IDLE after one handshake.

Source files
------------

// File: rtl/pe_row_collector.sv
// pe_row_collector: snapshots one mesh row of PE words and streams them out over valid/ready,
// flagging non-monotonic data fields and capture requests that arrive mid-burst.
module pe_row_collector #(
    parameter int N_COLS     = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    localparam int W  = ADDR_WIDTH + DATA_WIDTH,
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sort_done,
    input  logic [N_COLS*W-1:0] i_PE_row,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W-1:0]      o_word,
    output logic [CW-1:0]     o_index,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_order_err,
    output logic              o_overrun
);
    typedef enum logic {IDLE, STREAM} state_e;
    state_e                state_q, state_d;
    logic [N_COLS*W-1:0]   buf_q, buf_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  order_err_q, order_err_d;
    logic                  overrun_q, overrun_d;
    logic [W-1:0]          cur_word;
    logic                  hs, at_last;

    assign cur_word = buf_q[int'(idx_q)*W +: W];
    assign at_last  = (idx_q == CW'(N_COLS - 1));
    assign hs       = (state_q == STREAM) && i_ready;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        order_err_d = order_err_q;
        overrun_d   = overrun_q;
        if (state_q == IDLE) begin
            if (i_sort_done) begin
                state_d = STREAM;
                buf_d   = i_PE_row;
                idx_d   = '0;
                prev_d  = '0;
            end
        end else begin
            if (hs && idx_q != '0 && cur_word[DATA_WIDTH-1:0] < prev_q)
                order_err_d = 1'b1;
            if (hs && !at_last) begin
                idx_d  = idx_q + CW'(1);
                prev_d = cur_word[DATA_WIDTH-1:0];
            end else if (hs && i_sort_done) begin
                // a capture coinciding with the final handshake starts the next burst back-to-back
                buf_d  = i_PE_row;
                idx_d  = '0;
                prev_d = '0;
            end else if (hs) begin
                state_d = IDLE;
                idx_d   = '0;
            end
            if (i_sort_done && !(hs && at_last))
                overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            idx_q       <= '0;
            prev_q      <= '0;
            order_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            order_err_q <= order_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_valid     = (state_q == STREAM);
    assign o_busy      = (state_q == STREAM);
    assign o_word      = cur_word;
    assign o_index     = idx_q;
    assign o_last      = at_last;
    assign o_order_err = order_err_q;
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_pe_row_collector.sv
// tb_pe_row_collector: randomized scoreboard bench; a row-level model queues expected words,
// a negedge monitor compares them and the sticky flags against the DUT.
module tb_pe_row_collector;
    localparam int N = 4, DW = 3, W = 6;

    logic           clk = 0, rst = 1, sd = 0, rdy = 0;
    logic [N*W-1:0] row = '0;
    logic           o_valid, o_last, o_busy, o_order_err, o_overrun;
    logic [W-1:0]   o_word;
    logic [1:0]     o_index;

    logic           sd1 = 0, rdy1 = 0;
    logic [W-1:0]   row1 = '0, w1;
    logic           v1, l1, b1, oe1, ov1;
    logic [0:0]     idx1;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    pe_row_collector #(.N_COLS(N), .ADDR_WIDTH(3), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_sort_done(sd), .i_PE_row(row), .o_valid(o_valid),
        .i_ready(rdy), .o_word(o_word), .o_index(o_index), .o_last(o_last),
        .o_busy(o_busy), .o_order_err(o_order_err), .o_overrun(o_overrun));

    pe_row_collector #(.N_COLS(1), .ADDR_WIDTH(3), .DATA_WIDTH(DW)) dut1 (
        .clk(clk), .rst(rst), .i_sort_done(sd1), .i_PE_row(row1), .o_valid(v1),
        .i_ready(rdy1), .o_word(w1), .o_index(idx1), .o_last(l1),
        .o_busy(b1), .o_order_err(oe1), .o_overrun(ov1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {logic [W-1:0] w; int idx;} item_t;
    item_t        q[$];
    int           pend = 0;
    logic         exp_oe = 0, exp_ov = 0;
    logic [W-1:0] cur[N];

    // reference: a burst is a list of N words; a capture is taken only when nothing is left
    // pending after this cycle's acceptance
    always @(posedge clk) if (!rst) begin
        int k, p0;
        bit h;
        item_t it;
        p0 = pend;
        h  = (pend > 0) && rdy;
        if (h) begin
            k = N - pend;
            if (k > 0 && cur[k][DW-1:0] < cur[k-1][DW-1:0]) exp_oe = 1;
            pend--;
        end
        if (sd) begin
            if (p0 == 0 || (p0 == 1 && h)) begin
                for (int c = 0; c < N; c++) begin
                    cur[c] = row[c*W +: W];
                    it.w = row[c*W +: W];
                    it.idx = c;
                    q.push_back(it);
                end
                pend = N;
            end else exp_ov = 1;
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("valid", o_valid, pend > 0);
        chk("busy", o_busy, pend > 0);
        chk("order_err", o_order_err, exp_oe);
        chk("overrun", o_overrun, exp_ov);
        if (o_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word: got %0h expected no word", o_word);
            end else begin
                chk("word", o_word, q[0].w);
                chk("index", o_index, q[0].idx);
                chk("last", o_last, q[0].idx == N-1);
                if (rdy) void'(q.pop_front());
            end
        end
    end

    task automatic drive(input bit s, input bit r, input logic [N*W-1:0] rw);
        sd = s;
        rdy = r;
        row = rw;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1;
        sd = 0;
        rdy = 0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_word", o_word, 0);
        chk("rst_index", o_index, 0);
        chk("rst_last", o_last, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_flags", {o_order_err, o_overrun}, 0);
        chk("rst_last_n1", l1, 1);
        q.delete();
        pend = 0;
        exp_oe = 0;
        exp_ov = 0;
        @(posedge clk);
        #1 rst = 0;
    endtask

    function automatic logic [N*W-1:0] mk(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [N*W-1:0] rnd_row();
        logic [N*W-1:0] r;
        int d = 0;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1)
            for (int c = 0; c < N; c++) begin
                d = d + $urandom_range(0, 2);
                if (d > 7) d = 7;
                r[c*W +: DW] = DW'(d);
            end
        return r;
    endfunction

    logic [N*W-1:0] A, B, O;

    initial begin
        A = mk(6'o01, 6'o12, 6'o23, 6'o34);
        B = mk(6'o40, 6'o51, 6'o62, 6'o77);
        O = mk(6'o11, 6'o24, 6'o32, 6'o45);
        @(posedge clk);
        #1;
        do_reset();
        drive(1, 1, A);
        repeat (5) drive(0, 1, rnd_row());
        drive(1, 0, A);
        for (int i = 0; i < 8; i++) drive(0, i[0], rnd_row());
        repeat (2) drive(0, 0, rnd_row());
        drive(1, 1, A);
        repeat (3) drive(0, 1, rnd_row());
        drive(1, 1, B);
        repeat (5) drive(0, 1, rnd_row());
        drive(1, 1, A);
        drive(0, 1, rnd_row());
        drive(1, 0, B);
        repeat (4) drive(0, 1, rnd_row());
        drive(1, 1, O);
        repeat (4) drive(0, 1, rnd_row());
        drive(1, 1, A);
        repeat (5) drive(0, 1, rnd_row());
        drive(1, 1, A);
        repeat (2) drive(0, 1, rnd_row());
        do_reset();
        repeat (3) drive(0, 1, rnd_row());
        sd1 = 1;
        row1 = 6'o57;
        @(posedge clk);
        #1 sd1 = 0;
        rdy1 = 1;
        chk("n1_valid", v1, 1);
        chk("n1_word", w1, 6'o57);
        chk("n1_index", idx1, 0);
        chk("n1_last", l1, 1);
        @(posedge clk);
        #1;
        chk("n1_idle", {v1, b1}, 0);
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, rnd_row());
        end
        repeat (8) drive(0, 1, rnd_row());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
